imem_loader: RTL and testbench
==============================

# imem_loader

Writer side of the instruction-memory / PC / IR fetch path: accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive word addresses starting from a programmable base. It sits between the bench- or host-facing load port and the memory's write port. It holds the processor's PC/IR updates off while loading, so the fetch path only reads a fully written program.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 16, instruction word width

Ports:
- CLK  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin a load; sampled only in IDLE
- BaseAddr  in  ADDR_W  first write address, latched on accepted Start
- WordCount  in  16  number of words to load, latched on accepted Start; 0 means none
- InValid  in  1  InData holds a word
- InData  in  DATA_W  instruction word
- InReady  out  1  loader can accept a word this cycle
- MemWrite  out  1  memory write strobe, one cycle per word
- MemAddr  out  ADDR_W  write address
- MemData  out  DATA_W  write data
- CpuHold  out  1  processor must not assert PCWrite/IRWrite
- Busy  out  1  load in progress
- Done  out  1  one-cycle pulse when the last write has been issued

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: InReady=0, CpuHold=0, Busy=0.
  - On Start=1: latch BaseAddr into the address counter and WordCount into the remaining counter.
  - Next state is LOAD if WordCount≠0, otherwise DONE.
- LOAD: InReady=1, Busy=1, CpuHold=1.
  - Accept a word when InValid&&InReady. Register MemData=InData and MemAddr=current address; assert MemWrite in the next cycle.
  - Then increment the address (wrapping from 2^ADDR_W−1 to 0) and decrement the remaining count.
  - Accepting the word that brings the remaining count to 0 moves the FSM to DONE.
  - InValid=0 leaves the state, counters and outputs unchanged, except that MemWrite deasserts.
- DONE: InReady=0, Busy=1, CpuHold=1, Done=1.
  - The write of the last accepted word (if any) is issued in this cycle.
  - Next state is always IDLE.
- Start is ignored outside IDLE. InValid outside LOAD is ignored, and no word is consumed.
- Reset (any time, including mid-load): state=IDLE. InReady, MemWrite, CpuHold, Busy and Done are 0; MemAddr and MemData are 0. A pending write is dropped, and the counters are cleared.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Start in cycle t puts the FSM in LOAD, with InReady=1, from cycle t+1.
- A word accepted in cycle t produces MemWrite=1 with its address and data in cycle t+1. This gives a throughput of 1 word/cycle with back-to-back writes at consecutive addresses.
- The last word accepted in cycle t produces its MemWrite and Done in the same cycle, t+1. CpuHold falls in t+2.
- For WordCount=0: Start at t, then DONE at t+1 with Done=1 and no MemWrite, then IDLE at t+2.
- MemWrite is never asserted for more than one cycle per accepted word.

## Structure
- Shared package loader_pkg holds:
  - the state enum (IDLE, LOAD, DONE)
  - the default ADDR_W and DATA_W constants, shared with the PC/IR/memory datapath blocks.
- One sub-module, load_addr_ctr: loadable ADDR_W-bit counter with wrap, load enable and increment enable.
- FSM, write register and remaining counter stay in imem_loader.

## Test plan
- Reset, then Start with BaseAddr=0x0001, WordCount=3, streaming 19, 20, 21 back-to-back → writes at addresses 1, 2, 3 on consecutive cycles; Done coincides with the write of 21; CpuHold=0 one cycle later.
- Same load with InValid low for 2 cycles between words → no extra MemWrite; the address sequence is still 1, 2, 3.
- BaseAddr=0xFFFF, WordCount=2, data 0xAAAA, 0x5555 → writes land at 0xFFFF, then 0x0000.
- WordCount=0 → Done pulses at t+1; MemWrite and InReady stay 0 throughout.
- Start re-pulsed mid-load, and InValid asserted while IDLE → both ignored; BaseAddr is not re-latched and no write occurs.
- Reset asserted one cycle after the 2nd of 4 words is accepted → all outputs 0 immediately; the 2nd write is not issued; a fresh Start loads normally.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and state type for the instruction-memory load path.
package loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 16;
    localparam int unsigned LOADER_DATA_W = 16;
    localparam int unsigned LOADER_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/load_addr_ctr.sv
// Loadable wrapping address counter; load takes priority over increment.
module load_addr_ctr #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Counter register; natural overflow gives the wrap to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into memory at consecutive addresses and holds
// the CPU's PC/IR updates off until the whole program has been written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W,
    parameter int unsigned DATA_W = LOADER_DATA_W
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [ADDR_W-1:0]       BaseAddr,
    input  logic [LOADER_CNT_W-1:0] WordCount,
    input  logic                    InValid,
    input  logic [DATA_W-1:0]       InData,
    output logic                    InReady,
    output logic                    MemWrite,
    output logic [ADDR_W-1:0]       MemAddr,
    output logic [DATA_W-1:0]       MemData,
    output logic                    CpuHold,
    output logic                    Busy,
    output logic                    Done
);

    loader_state_t           state;
    loader_state_t           state_next;
    logic [LOADER_CNT_W-1:0] remaining;
    logic [ADDR_W-1:0]       addr;
    logic                    start_ok;
    logic                    accept;

    // Next-state decode plus the start/accept strobes for the datapath.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    start_ok   = 1'b1;
                    state_next = (WordCount != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (InValid && InReady) begin
                    accept = 1'b1;
                    if (remaining == LOADER_CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Words still to be accepted in the current load.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            remaining <= '0;
        end else if (start_ok) begin
            remaining <= WordCount;
        end else if (accept) begin
            remaining <= remaining - LOADER_CNT_W'(1);
        end
    end

    // Write address: latched from BaseAddr on start, advanced per accepted word.
    load_addr_ctr #(
        .W (ADDR_W)
    ) u_addr_ctr (
        .clk  (CLK),
        .rst  (Reset),
        .load (start_ok),
        .inc  (accept),
        .d    (BaseAddr),
        .q    (addr)
    );

    // Memory write register: one strobe in the cycle after each accepted word.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            MemWrite <= 1'b0;
            MemAddr  <= '0;
            MemData  <= '0;
        end else begin
            MemWrite <= accept;
            if (accept) begin
                MemAddr <= addr;
                MemData <= InData;
            end
        end
    end

    // Status outputs registered from the next state so they track the FSM exactly.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            InReady <= 1'b0;
            Busy    <= 1'b0;
            CpuHold <= 1'b0;
            Done    <= 1'b0;
        end else begin
            InReady <= (state_next == LOAD);
            Busy    <= (state_next != IDLE);
            CpuHold <= (state_next != IDLE);
            Done    <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-level expectations derived from
// the load protocol (address = base + index mod 2^16, write one cycle after accept).
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] BaseAddr;
    logic [15:0] WordCount;
    logic        InValid;
    logic [15:0] InData;
    logic        InReady;
    logic        MemWrite;
    logic [15:0] MemAddr;
    logic [15:0] MemData;
    logic        CpuHold;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] load_data[$];

    imem_loader dut (
        .CLK       (clk),
        .Reset     (rst),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .WordCount (WordCount),
        .InValid   (InValid),
        .InData    (InData),
        .InReady   (InReady),
        .MemWrite  (MemWrite),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .CpuHold   (CpuHold),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete load: status is {InReady,Busy,CpuHold,Done,MemWrite}.
    // gap_mode: 0 = back-to-back, 1 = two idle cycles between words, 2 = random.
    task automatic do_load(input string name, input logic [15:0] base, input logic [15:0] cnt,
                           input int gap_mode, input bit poke_idle, input bit repulse);
        int          cnt_i = int'(cnt);
        int          sent = 0;
        int          cyc = 0;
        int          gap_left = 0;
        bit          acc_prev = 1'b0;
        bit          valid;
        logic [15:0] exp_addr = '0;
        logic [15:0] exp_data = '0;
        logic [4:0]  exp_st;

        while (load_data.size() < cnt_i) load_data.push_back(16'($urandom));

        @(negedge clk);
        n_checks++;
        if ({InReady, Busy, CpuHold, Done, MemWrite} !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s idle_before: status %b required 00000", name,
                     {InReady, Busy, CpuHold, Done, MemWrite});
        end
        if (poke_idle) begin
            InValid = 1'b1;
            InData  = 16'hDEAD;
            @(negedge clk);
            n_checks++;
            if ({InReady, MemWrite, Busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL %s idle_invalid: ready/write/busy %b required 000", name,
                         {InReady, MemWrite, Busy});
            end
        end
        InValid   = 1'b0;
        Start     = 1'b1;
        BaseAddr  = base;
        WordCount = cnt;
        @(negedge clk);
        Start     = 1'b0;
        BaseAddr  = ~base;
        WordCount = 16'($urandom);

        if (cnt_i == 0) begin
            InValid = 1'b1;
            n_checks++;
            if ({InReady, Busy, CpuHold, Done, MemWrite} !== 5'b01110) begin
                n_fail++;
                $display("FAIL %s zero_done: status %b required 01110", name,
                         {InReady, Busy, CpuHold, Done, MemWrite});
            end
            @(negedge clk);
            InValid = 1'b0;
            n_checks++;
            if ({InReady, Busy, CpuHold, Done, MemWrite} !== 5'b00000) begin
                n_fail++;
                $display("FAIL %s zero_idle: status %b required 00000", name,
                         {InReady, Busy, CpuHold, Done, MemWrite});
            end
            load_data.delete();
            return;
        end

        while (sent < cnt_i && cyc < 8 * cnt_i + 16) begin
            exp_st = {4'b1110, acc_prev};
            n_checks++;
            if ({InReady, Busy, CpuHold, Done, MemWrite} !== exp_st) begin
                n_fail++;
                $display("FAIL %s load_status cyc %0d: status %b required %b", name, cyc,
                         {InReady, Busy, CpuHold, Done, MemWrite}, exp_st);
            end
            if (acc_prev) begin
                n_checks++;
                if (MemAddr !== exp_addr || MemData !== exp_data) begin
                    n_fail++;
                    $display("FAIL %s write %0d: addr/data %h/%h required %h/%h", name, sent - 1,
                             MemAddr, MemData, exp_addr, exp_data);
                end
            end
            Start = repulse && (cyc == 1);
            case (gap_mode)
                0:       valid = 1'b1;
                1:       valid = (gap_left == 0);
                default: valid = ($urandom_range(0, 2) != 0) || (cyc > 4 * cnt_i);
            endcase
            if (valid) begin
                InValid  = 1'b1;
                InData   = load_data[sent];
                exp_addr = 16'(int'(base) + sent);
                exp_data = load_data[sent];
                sent++;
                gap_left = 2;
                acc_prev = 1'b1;
            end else begin
                InValid  = 1'b0;
                InData   = 16'($urandom);
                if (gap_left > 0) gap_left--;
                acc_prev = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        InValid = 1'b0;
        Start   = 1'b0;
        if (sent < cnt_i) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: sent %0d required %0d", name, sent, cnt_i);
        end

        n_checks++;
        if ({InReady, Busy, CpuHold, Done, MemWrite} !== 5'b01111) begin
            n_fail++;
            $display("FAIL %s last_done: status %b required 01111", name,
                     {InReady, Busy, CpuHold, Done, MemWrite});
        end
        n_checks++;
        if (MemAddr !== exp_addr || MemData !== exp_data) begin
            n_fail++;
            $display("FAIL %s last_write: addr/data %h/%h required %h/%h", name,
                     MemAddr, MemData, exp_addr, exp_data);
        end
        @(negedge clk);
        n_checks++;
        if ({InReady, Busy, CpuHold, Done, MemWrite} !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s release: status %b required 00000", name,
                     {InReady, Busy, CpuHold, Done, MemWrite});
        end
        load_data.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        Start     = 1'b0;
        BaseAddr  = '0;
        WordCount = '0;
        InValid   = 1'b0;
        InData    = '0;
        #2;
        n_checks++;
        if ({InReady, Busy, CpuHold, Done, MemWrite, MemAddr, MemData} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset: outputs %h required 0",
                     {InReady, Busy, CpuHold, Done, MemWrite, MemAddr, MemData});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        load_data = '{16'd19, 16'd20, 16'd21};
        do_load("basic", 16'h0001, 16'd3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        load_data = '{16'd19, 16'd20, 16'd21};
        do_load("gaps", 16'h0001, 16'd3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        load_data = '{16'hAAAA, 16'h5555};
        do_load("wrap", 16'hFFFF, 16'd2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        do_load("zero", 16'h1234, 16'd0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored();
        do_load("ignored", 16'h0040, 16'd4, 2, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        Start     = 1'b1;
        BaseAddr  = 16'h0100;
        WordCount = 16'd4;
        @(negedge clk);
        Start   = 1'b0;
        InValid = 1'b1;
        InData  = 16'h1111;
        @(negedge clk);
        InData = 16'h2222;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        InValid = 1'b0;
        #1;
        n_checks++;
        if ({InReady, Busy, CpuHold, Done, MemWrite, MemAddr, MemData} !== 37'd0) begin
            n_fail++;
            $display("FAIL midload_reset: outputs %h required 0",
                     {InReady, Busy, CpuHold, Done, MemWrite, MemAddr, MemData});
        end
        @(negedge clk);
        n_checks++;
        if ({InReady, Busy, CpuHold, Done, MemWrite} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midload_reset_hold: status %b required 00000",
                     {InReady, Busy, CpuHold, Done, MemWrite});
        end
        rst = 1'b0;
        do_load("after_reset", 16'h0200, 16'd3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_load("random", 16'($urandom), 16'($urandom_range(1, 6)), 2, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_zero();
        test_ignored();
        test_reset_midload();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
